red_pitaya_bus_master: RTL and testbench

System bus initiator that converts a valid/ready command stream into single-transfer `sys_wen`/`sys_ren` strobes on the Red Pitaya system bus. It waits for `sys_ack`/`sys_err` from a responder such as the housekeeping block and returns a response with read data, an error flag and a timeout flag. It sits between an internal sequencer or debug agent and the bus address decoder, so FPGA logic can access housekeeping, LED and expansion registers without the PS.

---
 rtl/red_pitaya_bus_defs.sv | 18 +
 rtl/red_pitaya_bus_master.sv | 171 +++++++++++++++++
 tb/tb_red_pitaya_bus_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_bus_defs.sv
// ============================================================================
// Module   : red_pitaya_bus_defs (package)
// Brief    : Shared Red Pitaya system-bus widths and default initiator timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package red_pitaya_bus_defs;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int SEL_W       = 4;
  localparam int CNT_W       = 16;
  localparam int DEF_TIMEOUT = 255;

endpackage

`default_nettype wire

// File: rtl/red_pitaya_bus_master.sv
// ============================================================================
// Module   : red_pitaya_bus_master
// Brief    : Valid/ready command stream to single-transfer system-bus initiator
//            with ack/err/timeout response channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module red_pitaya_bus_master
  import red_pitaya_bus_defs::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_tmo_o,
  output logic [ADDR_W-1:0] sys_addr_o,
  output logic [DATA_W-1:0] sys_wdata_o,
  output logic [SEL_W-1:0]  sys_sel_o,
  output logic              sys_wen_o,
  output logic              sys_ren_o,
  input  logic [DATA_W-1:0] sys_rdata_i,
  input  logic              sys_err_i,
  input  logic              sys_ack_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              we_q,        we_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              rsp_tmo_q,   rsp_tmo_d;
  logic [ADDR_W-1:0] sys_addr_q,  sys_addr_d;
  logic [DATA_W-1:0] sys_wdata_q, sys_wdata_d;
  logic [SEL_W-1:0]  sys_sel_q,   sys_sel_d;
  logic              sys_wen_q,   sys_wen_d;
  logic              sys_ren_q,   sys_ren_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    sys_addr_d  = sys_addr_q;
    sys_wdata_d = sys_wdata_q;
    sys_sel_d   = sys_sel_q;
    sys_wen_d   = 1'b0;
    sys_ren_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ready rises one clock after reset release, so the handshake uses the registered copy.
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          we_d        = cmd_we_i;
          sys_addr_d  = cmd_addr_i;
          sys_wdata_d = cmd_wdata_i;
          sys_sel_d   = cmd_sel_i;
          sys_wen_d   = cmd_we_i;
          sys_ren_d   = ~cmd_we_i;
          cnt_d       = '0;
          state_d     = S_STROBE;
        end
      end

      S_STROBE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (sys_ack_i || sys_err_i) begin
          rsp_rdata_d = we_q ? '0 : sys_rdata_i;
          rsp_err_d   = sys_err_i;
          rsp_tmo_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == C_CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      sys_addr_q  <= '0;
      sys_wdata_q <= '0;
      sys_sel_q   <= '0;
      sys_wen_q   <= 1'b0;
      sys_ren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      sys_addr_q  <= sys_addr_d;
      sys_wdata_q <= sys_wdata_d;
      sys_sel_q   <= sys_sel_d;
      sys_wen_q   <= sys_wen_d;
      sys_ren_q   <= sys_ren_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tmo_o   = rsp_tmo_q;
  assign sys_addr_o  = sys_addr_q;
  assign sys_wdata_o = sys_wdata_q;
  assign sys_sel_o   = sys_sel_q;
  assign sys_wen_o   = sys_wen_q;
  assign sys_ren_o   = sys_ren_q;

endmodule

`default_nettype wire

// File: tb/tb_red_pitaya_bus_master.sv
// ============================================================================
// Module   : tb_red_pitaya_bus_master
// Brief    : Directed bench with a housekeeping-like responder and a response
//            scoreboard for red_pitaya_bus_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_red_pitaya_bus_master;
  import red_pitaya_bus_defs::*;

  localparam int TMO = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_tmo_o;
  logic [31:0] sys_addr_o;
  logic [31:0] sys_wdata_o;
  logic [3:0]  sys_sel_o;
  logic        sys_wen_o;
  logic        sys_ren_o;
  logic [31:0] sys_rdata_i = '0;
  logic        sys_err_i   = 1'b0;
  logic        sys_ack_i   = 1'b0;

  rsp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // responder configuration
  int          lat      = 1;
  bit          silent   = 1'b0;
  bit          give_ack = 1'b1;
  bit          give_err = 1'b0;
  bit          ack_hold = 1'b0;
  int          stray    = 0;
  int          pend     = 0;
  int          pend2    = 0;
  logic [31:0] led      = '0;
  logic [31:0] cur_rdata = '0;
  logic        cur_we   = 1'b0;

  red_pitaya_bus_master #(.TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_tmo_o   (rsp_tmo_o),
    .sys_addr_o  (sys_addr_o),
    .sys_wdata_o (sys_wdata_o),
    .sys_sel_o   (sys_sel_o),
    .sys_wen_o   (sys_wen_o),
    .sys_ren_o   (sys_ren_o),
    .sys_rdata_i (sys_rdata_i),
    .sys_err_i   (sys_err_i),
    .sys_ack_i   (sys_ack_i)
  );

  always #5 clk = ~clk;

  // Housekeeping-like responder: ID register at 0x00 reads 1, LED register at 0x30.
  initial forever begin
    @(negedge clk);
    sys_ack_i   = ack_hold;
    sys_err_i   = 1'b0;
    sys_rdata_i = ack_hold ? cur_rdata : 32'h0;
    if (!rstn_i) begin
      pend  = 0;
      pend2 = 0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        sys_ack_i   = give_ack;
        sys_err_i   = give_err;
        sys_rdata_i = cur_we ? 32'hBAD0_BAD0 : cur_rdata;
      end
    end
    if (pend2 > 0) begin
      pend2--;
      if (pend2 == 0) begin
        sys_ack_i   = 1'b1;
        sys_rdata_i = 32'hCAFE_0000;
      end
    end
    if (rstn_i && (sys_wen_o || sys_ren_o)) begin
      cur_we = sys_wen_o;
      if (sys_wen_o && sys_addr_o == 32'h30) begin
        for (int b = 0; b < 4; b++)
          if (sys_sel_o[b]) led[8*b +: 8] = sys_wdata_o[8*b +: 8];
      end
      cur_rdata = (sys_addr_o == 32'h0)  ? 32'h1 :
                  (sys_addr_o == 32'h30) ? led : 32'h0;
      if (!silent)   pend  = lat;
      if (stray > 0) pend2 = stray;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ":cmd_ready"}, 32'(cmd_ready_o), 32'h0);
    chk({tag, ":rsp_flags"}, 32'({rsp_valid_o, rsp_err_o, rsp_tmo_o}), 32'h0);
    chk({tag, ":strobes"},   32'({sys_wen_o, sys_ren_o}), 32'h0);
    chk({tag, ":rsp_rdata"}, rsp_rdata_o, 32'h0);
    chk({tag, ":sys_addr"},  sys_addr_o, 32'h0);
    chk({tag, ":sys_wdata"}, sys_wdata_o, 32'h0);
    chk({tag, ":sys_sel"},   32'(sys_sel_o), 32'h0);
  endtask

  // Entered and left at a negedge; the exit point is the IDLE cycle after the response handshake.
  task automatic run_cmd(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel,
                         input logic [31:0] e_rdata, input logic e_err, input logic e_tmo,
                         input int e_cyc, input int hold);
    rsp_t exp;
    int   c;
    bit   seen;
    chk({tag, ":cmd_ready"}, 32'(cmd_ready_o), 32'h1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_sel_i   = sel;
    sb.push_back('{rdata: e_rdata, err: e_err, tmo: e_tmo});
    @(posedge clk);
    c    = 0;
    seen = 1'b0;
    while (!seen && c < 100) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        cmd_valid_i = 1'b0;
        cmd_addr_i  = 32'hFFFF_FFFF;
        cmd_wdata_i = 32'hFFFF_FFFF;
        cmd_sel_i   = 4'h0;
        chk({tag, ":strobe_c1"}, 32'({sys_wen_o, sys_ren_o}), 32'({we, ~we}));
        chk({tag, ":sys_addr"},  sys_addr_o, addr);
        chk({tag, ":sys_wdata"}, sys_wdata_o, wdata);
        chk({tag, ":sys_sel"},   32'(sys_sel_o), 32'(sel));
        chk({tag, ":ready_busy"}, 32'(cmd_ready_o), 32'h0);
      end else begin
        chk({tag, ":strobe_low"}, 32'({sys_wen_o, sys_ren_o}), 32'h0);
      end
      seen = rsp_valid_o;
    end
    chk({tag, ":rsp_cycle"}, 32'(c), 32'(e_cyc));
    if (!seen) begin
      void'(sb.pop_front());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk({tag, ":hold_valid"}, 32'(rsp_valid_o), 32'h1);
      chk({tag, ":hold_rdata"}, rsp_rdata_o, e_rdata);
      chk({tag, ":hold_flags"}, 32'({rsp_err_o, rsp_tmo_o}), 32'({e_err, e_tmo}));
      chk({tag, ":hold_ready"}, 32'(cmd_ready_o), 32'h0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    exp = sb.pop_front();
    chk({tag, ":rsp_valid"}, 32'(rsp_valid_o), 32'h1);
    chk({tag, ":rsp_rdata"}, rsp_rdata_o, exp.rdata);
    chk({tag, ":rsp_err"},   32'(rsp_err_o), 32'(exp.err));
    chk({tag, ":rsp_tmo"},   32'(rsp_tmo_o), 32'(exp.tmo));
    chk({tag, ":addr_stable"}, sys_addr_o, addr);
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk({tag, ":idle_valid"}, 32'(rsp_valid_o), 32'h0);
    chk({tag, ":idle_ready"}, 32'(cmd_ready_o), 32'h1);
  endtask

  initial begin
    rstn_i      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rstn_i = 1'b1;
    #1 chk("por:ready_before_clk", 32'(cmd_ready_o), 32'h0);
    @(negedge clk);

    run_cmd("wr_led",   1'b1, 32'h30, 32'hFE, 4'hF, 32'h0,  1'b0, 1'b0, 3, 0);
    run_cmd("rd_led",   1'b0, 32'h30, 32'h0,  4'hF, 32'hFE, 1'b0, 1'b0, 3, 0);
    run_cmd("rd_id",    1'b0, 32'h00, 32'h0,  4'hF, 32'h1,  1'b0, 1'b0, 3, 0);

    silent = 1'b1;
    run_cmd("timeout",  1'b0, 32'h30, 32'h0,  4'hF, 32'h0,  1'b1, 1'b1, TMO + 2, 0);
    silent = 1'b0;

    lat = TMO;
    run_cmd("last_ack", 1'b0, 32'h00, 32'h0,  4'hF, 32'h1,  1'b0, 1'b0, TMO + 2, 0);

    lat = 3; give_ack = 1'b0; give_err = 1'b1; stray = 5;
    run_cmd("err_wait", 1'b0, 32'h00, 32'h0,  4'hF, 32'h1,  1'b1, 1'b0, 5, 3);
    stray = 0;

    lat = 1; give_ack = 1'b1; give_err = 1'b1;
    run_cmd("ack_err",  1'b0, 32'h30, 32'h0,  4'hF, 32'hFE, 1'b1, 1'b0, 3, 0);
    give_err = 1'b0;

    run_cmd("wr_sel3",  1'b1, 32'h30, 32'h1234_5678, 4'h3, 32'h0, 1'b0, 1'b0, 3, 0);
    run_cmd("rd_hold5", 1'b0, 32'h30, 32'h0,  4'hF, 32'h5678, 1'b0, 1'b0, 3, 5);

    ack_hold = 1'b1;
    run_cmd("ack_hold", 1'b0, 32'h00, 32'h0,  4'hF, 32'h1,  1'b0, 1'b0, 3, 0);
    ack_hold = 1'b0;

    // Reset while the transfer sits in WAIT: no response may appear.
    silent = 1'b1;
    chk("rst:cmd_ready", 32'(cmd_ready_o), 32'h1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = 32'h0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("rst:strobe", 32'({sys_wen_o, sys_ren_o}), 32'h1);
    @(negedge clk);
    @(negedge clk);
    #1 rstn_i = 1'b0;
    #1 check_reset_vals("rst_wait");
    repeat (3) begin
      @(negedge clk);
      chk("rst:no_rsp", 32'(rsp_valid_o), 32'h0);
    end
    rstn_i = 1'b1;
    silent = 1'b0;
    #1 chk("rst:ready_before_clk", 32'(cmd_ready_o), 32'h0);
    @(negedge clk);
    run_cmd("rd_after_rst", 1'b0, 32'h00, 32'h0, 4'hF, 32'h1, 1'b0, 1'b0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
